// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response bundle for the iterative RV32M multiply/divide unit
interface muldiv_unit_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0]      rd_in;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd_in, flush,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd_in, flush,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit; `MULDIV_FAST_MUL_EN selects a single-cycle multiplier
// Shift-add multiply and restoring divide on operand magnitudes, sign fixed up on the way into DONE.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state;
  logic [2:0]      r_op;
  logic [4:0]      r_rd;
  logic [4:0]      r_rd_out;
  logic [XLEN-1:0] r_m;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [CW-1:0]   r_cnt;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  logic            w_sa, w_sb, w_neg_a, w_neg_b;
  logic [XLEN-1:0] w_mag_a, w_mag_b;
  logic            w_div0, w_ovf, w_short;
  logic [XLEN-1:0] w_short_res;

  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_tmp;
  logic              w_ge;
  logic [XLEN-1:0]   w_diff;
  logic [XLEN-1:0]   w_hi_n, w_lo_n;
  logic [2*XLEN-1:0] w_prod, w_prod_s;
  logic [XLEN-1:0]   w_quo_s, w_rem_s, w_final;

  // Operand signedness: divides are signed on even funct3, MULHSU/MULHU drop the rs2 sign.
  assign w_sa    = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
  assign w_sb    = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
  assign w_neg_a = w_sa & bus.rs1_data[XLEN-1];
  assign w_neg_b = w_sb & bus.rs2_data[XLEN-1];
  assign w_mag_a = w_neg_a ? -bus.rs1_data : bus.rs1_data;
  assign w_mag_b = w_neg_b ? -bus.rs2_data : bus.rs2_data;

  assign w_div0 = bus.funct3[2] && (bus.rs2_data == '0);
  assign w_ovf  = bus.funct3[2] && !bus.funct3[0] &&
                  (bus.rs1_data == MIN_NEG) && (bus.rs2_data == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN+1:0] w_fast;
  assign w_fast = $signed({w_neg_a, bus.rs1_data}) * $signed({w_neg_b, bus.rs2_data});
`endif

  always_comb begin
    w_short     = 1'b0;
    w_short_res = '0;
    if (w_div0) begin
      w_short     = 1'b1;
      w_short_res = bus.funct3[1] ? bus.rs1_data : '1;
    end else if (w_ovf) begin
      w_short     = 1'b1;
      w_short_res = bus.funct3[1] ? '0 : MIN_NEG;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (!bus.funct3[2]) begin
      w_short     = 1'b1;
      w_short_res = (bus.funct3[1:0] == 2'b00) ? w_fast[XLEN-1:0] : w_fast[2*XLEN-1:XLEN];
    end
`endif
  end

  // One CALC step. Multiply: r_lo holds the multiplier and shifts out as the product shifts in.
  // Divide: r_lo holds the dividend and shifts in quotient bits, r_hi is the partial remainder.
  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
    w_tmp  = {r_hi, r_lo[XLEN-1]};
    w_ge   = (w_tmp >= {1'b0, r_m});
    w_diff = w_tmp[XLEN-1:0] - r_m;
    if (r_op[2]) begin
      w_hi_n = w_ge ? w_diff : w_tmp[XLEN-1:0];
      w_lo_n = {r_lo[XLEN-2:0], w_ge};
    end else begin
      w_hi_n = w_sum[XLEN:1];
      w_lo_n = {w_sum[0], r_lo[XLEN-1:1]};
    end
    w_prod   = {w_hi_n, w_lo_n};
    w_prod_s = r_neg_q ? -w_prod : w_prod;
    w_quo_s  = r_neg_q ? -w_lo_n : w_lo_n;
    w_rem_s  = r_neg_r ? -w_hi_n : w_hi_n;
    if (!r_op[2])
      w_final = (r_op[1:0] == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
    else
      w_final = r_op[1] ? w_rem_s : w_quo_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_rd     <= '0;
      r_rd_out <= '0;
      r_m      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.flush) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              r_op    <= bus.funct3;
              r_rd    <= bus.rd_in;
              r_neg_q <= w_neg_a ^ w_neg_b;
              r_neg_r <= w_neg_a;
              r_m     <= bus.funct3[2] ? w_mag_b : w_mag_a;
              r_lo    <= bus.funct3[2] ? w_mag_a : w_mag_b;
              r_hi    <= '0;
              r_cnt   <= '0;
              if (w_short) begin
                r_result <= w_short_res;
                r_rd_out <= bus.rd_in;
                r_done   <= 1'b1;
                r_state  <= S_DONE;
              end else begin
                r_state  <= S_CALC;
              end
            end
          end
          S_CALC: begin
            r_hi  <= w_hi_n;
            r_lo  <= w_lo_n;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(XLEN-1)) begin
              r_result <= w_final;
              r_rd_out <= r_rd;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy   = (r_state != S_IDLE);
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.rd_out = r_rd_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(32)) bus ();
  muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic prev_done = 1'b0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      p;
    logic [63:0] u;
    int          sa, sbv;
    sa  = a;
    sbv = b;
    case (f3)
      3'b000: begin p = longint'(sa) * longint'(sbv); return p[31:0]; end
      3'b001: begin p = longint'(sa) * longint'(sbv); return p[63:32]; end
      3'b010: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
      3'b011: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
        return sa / sbv;
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sbv;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2])
      return (b == 0 || (!f3[0] && a == MINV && b == 32'hFFFF_FFFF)) ? 0 : 32;
`ifdef MULDIV_FAST_MUL_EN
    return 0;
`else
    return 32;
`endif
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return MINV;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done) begin
      check("done_gap", 64'(prev_done), 64'd0);
      if (exp_q.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", 64'(bus.result), 64'(e.res));
        check("rd_out", 64'(bus.rd_out), 64'(e.rd));
        check("latency", 64'(cyc), 64'(e.due));
      end
    end
    prev_done <= bus.done;
  end

  task automatic wait_idle();
    int w = 0;
    while (bus.busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    wait_idle();
    bus.start    = 1'b1;
    bus.funct3   = f3;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_in    = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e.res = model(f3, a, b);
    e.rd  = rd;
    e.due = cyc + latency(f3, a, b);
    exp_q.push_back(e);
    last_res = e.res;
    last_rd  = rd;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] saved_res;
    logic [4:0]  saved_rd;
    rst = 1'b1;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
    bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_in = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   64'(bus.busy),   64'd0);
    check("reset_done",   64'(bus.done),   64'd0);
    check("reset_result", 64'(bus.result), 64'd0);
    check("reset_rd_out", 64'(bus.rd_out), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(3'b100, 32'd7, 32'd2, 5'd5);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6);
    issue(3'b101, 32'd5, 32'd0, 5'd7);
    issue(3'b111, 32'd5, 32'd0, 5'd8);
    issue(3'b100, MINV, 32'hFFFF_FFFF, 5'd9);
    issue(3'b110, MINV, 32'hFFFF_FFFF, 5'd10);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12);
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13);
    issue(3'b010, 32'hFFFF_FFFF, 32'd2, 5'd14);

    // A start while busy must leave the in-flight divide untouched.
    issue(3'b101, 32'd100, 32'd7, 5'd15);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.funct3 = 3'b000; bus.rs1_data = 32'd9; bus.rs2_data = 32'd9; bus.rd_in = 5'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    issue(3'b000, 32'd6, 32'd7, 5'd16);
    drain();

    saved_res = last_res;
    saved_rd  = last_rd;
    issue(3'b100, 32'd1000, 32'd7, 5'd3);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    void'(exp_q.pop_back());
    check("flush_busy",   64'(bus.busy),   64'd0);
    check("flush_result", 64'(bus.result), 64'(saved_res));
    check("flush_rd_out", 64'(bus.rd_out), 64'(saved_rd));
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'b101;
    bus.rs1_data = 32'd50; bus.rs2_data = 32'd3; bus.rd_in = 5'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_start_busy", 64'(bus.busy), 64'd0);
    repeat (40) @(negedge clk);
    check("flush_hold_result", 64'(bus.result), 64'(saved_res));

    issue(3'b100, 32'd12345, 32'd17, 5'd2);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    check("rst_busy",   64'(bus.busy),   64'd0);
    check("rst_done",   64'(bus.done),   64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_rd_out", 64'(bus.rd_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(3'b000, 32'd3, 32'd4, 5'd17);

    for (int i = 0; i < 60; i++)
      issue(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(), 5'($urandom_range(0, 31)));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the EX stage. Consumes the two source operands produced by the register file read (after forwarding) plus the destination register address. Computes the result over multiple cycles, then returns it with the destination address to the writeback path. The pipeline stalls while busy is high.

Parameters:
XLEN, 32, operand/result width; only 32 is supported, the counter width is log2(XLEN)+1.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  request; accepted only when busy=0 and flush=0
funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data  input  XLEN  operand A (dividend / multiplicand)
rs2_data  input  XLEN  operand B (divisor / multiplier)
rd_in  input  5  destination register address
flush  input  1  synchronous abort (branch mispredict / trap)
busy  output  1  high from the cycle after accept through the DONE cycle
done  output  1  one-cycle pulse; result and rd_out are valid
result  output  XLEN  computed value; held until the next accepted start
rd_out  output  5  rd_in latched at accept

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, result=0, rd_out=0, all internal registers 0. Reset mid-operation discards the operation and produces no done.
- FSM states:
  - IDLE: on accept, latch funct3 and rd_in, latch operand magnitudes and sign flags, clear the counter. Next state is DONE for special cases, otherwise CALC.
  - CALC: one bit per cycle; go to DONE after the counter reaches XLEN-1 (32 CALC cycles).
  - DONE: drive done=1, write result, return to IDLE.
- busy = (state != IDLE). A start while busy is ignored and has no effect on the in-flight operation.
- Latency, measured from the accept cycle T: iterative ops raise done in cycle T+33; special cases raise done in cycle T+1.
- Back-to-back: start may be accepted in the cycle after done (state is IDLE).
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Signed ops operate on magnitudes; the sign is corrected in DONE.
- Multiply: shift-add 2*XLEN-bit product. MUL returns the low word; MULH, MULHSU and MULHU return the high word. Product sign is the XOR of the operand signs.
- Divide: restoring, one quotient bit per CALC cycle. Quotient sign = XOR of the operand signs; remainder sign = dividend sign.
- Special cases (no CALC):
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return rs1.
  - DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000.
  - REM 0x80000000 % 0xFFFFFFFF returns 0.
- flush: in any state, next state is IDLE; done is not asserted; result and rd_out keep their previous values. flush together with start: flush wins and start is dropped.
- done is never asserted in two consecutive cycles.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: the four MUL ops use a single-cycle combinational 33x33 signed multiply and go IDLE→DONE, so done arrives at T+1. Divide is unchanged.
- Undefined: multiply uses the 32-cycle shift-add path, done at T+33. No combinational multiplier is inferred.

Test Plan:
- DIV 7/2, rd_in=5 -> done at T+33, result=3, rd_out=5; REM 0xFFFFFFF9 (-7) % 2 -> result=0xFFFFFFFF.
- DIVU 5/0 -> done at T+1, result=0xFFFFFFFF; REMU 5%0 -> result=5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU of the same operands -> 0xFFFFFFFE; MUL of the same operands -> 0x00000001; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF. done at T+33, or T+1 with MULDIV_FAST_MUL_EN.
- DIVU 100/7 started, second start at T+5 with other operands -> second start ignored, done at T+33 with result=14; new start at T+34 accepted.
- DIV started, flush at T+10 -> busy=0 at T+11, no done pulse, result unchanged; flush and start in the same cycle -> busy stays 0.
- rst asserted at T+20 of DIV -> busy=0, done=0, result=0, rd_out=0 immediately; after release, MUL 3*4 -> result=12.
